// File: rtl/gray_bus_arbiter.sv
// Round-robin arbiter that shares the gray-coding bus among NREQ requesters.
// It runs one transaction at a time: grant, drive the bus for BEATS cycles, capture dataout, respond.
module gray_bus_arbiter #(
  parameter int NREQ  = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int BEATS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  input  logic [NREQ-1:0]  req_rw,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  rsp_valid,
  output logic [DW-1:0]    rsp_data,
  output logic             busy,
  output logic             dut_en,
  output logic [AW-1:0]    dut_addr,
  output logic [DW-1:0]    dut_datain,
  output logic             dut_rw,
  input  logic [DW-1:0]    dut_dataout
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, XFER, RESP} state_t;

  state_t            state_q;
  logic [PW-1:0]     ptr_q;
  logic [PW-1:0]     owner_q;
  logic [CW-1:0]     cnt_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   rsp_valid_q;
  logic [DW-1:0]     rsp_data_q;
  logic              busy_q;
  logic              dut_en_q;
  logic [AW-1:0]     dut_addr_q;
  logic [DW-1:0]     dut_datain_q;
  logic              dut_rw_q;

  logic              win_vld_d;
  logic [PW-1:0]     win_idx_d;

  // Search starts just after the last owner, so the previous winner ranks lowest.
  always_comb begin
    int j;
    j         = 0;
    win_vld_d = 1'b0;
    win_idx_d = '0;
    for (int k = 1; k <= NREQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= NREQ) j = j - NREQ;
      if (!win_vld_d && req[PW'(j)]) begin
        win_vld_d = 1'b1;
        win_idx_d = PW'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      ptr_q        <= PW'(NREQ - 1);
      owner_q      <= '0;
      cnt_q        <= '0;
      gnt_q        <= '0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      busy_q       <= 1'b0;
      dut_en_q     <= 1'b0;
      dut_addr_q   <= '0;
      dut_datain_q <= '0;
      dut_rw_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_vld_d) begin
            gnt_q        <= ONE << win_idx_d;
            owner_q      <= win_idx_d;
            dut_addr_q   <= req_addr[win_idx_d*AW +: AW];
            dut_datain_q <= req_data[win_idx_d*DW +: DW];
            dut_rw_q     <= req_rw[win_idx_d];
            cnt_q        <= CW'(BEATS - 1);
            dut_en_q     <= 1'b1;
            busy_q       <= 1'b1;
            state_q      <= XFER;
          end
        end
        XFER: begin
          gnt_q <= '0;
          if (cnt_q == '0) begin
            rsp_data_q  <= dut_dataout;
            rsp_valid_q <= ONE << owner_q;
            dut_en_q    <= 1'b0;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        RESP: begin
          // Only a completed transaction moves the pointer, which keeps rotation fair.
          rsp_valid_q <= '0;
          ptr_q       <= owner_q;
          busy_q      <= 1'b0;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign busy       = busy_q;
  assign dut_en     = dut_en_q;
  assign dut_addr   = dut_addr_q;
  assign dut_datain = dut_datain_q;
  assign dut_rw     = dut_rw_q;

endmodule

// File: tb/tb_gray_bus_arbiter.sv
// Directed bench for gray_bus_arbiter (NREQ=4, AW=DW=32, BEATS=16).
module tb_gray_bus_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req;
  logic [127:0] req_addr;
  logic [127:0] req_data;
  logic [3:0]   req_rw;
  logic [3:0]   gnt;
  logic [3:0]   rsp_valid;
  logic [31:0]  rsp_data;
  logic         busy;
  logic         dut_en;
  logic [31:0]  dut_addr;
  logic [31:0]  dut_datain;
  logic         dut_rw;
  logic [31:0]  dut_dataout;

  int checks   = 0;
  int failures = 0;

  gray_bus_arbiter #(.NREQ(4), .AW(32), .DW(32), .BEATS(16)) dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .req_rw(req_rw), .gnt(gnt), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .dut_en(dut_en), .dut_addr(dut_addr), .dut_datain(dut_datain),
    .dut_rw(dut_rw), .dut_dataout(dut_dataout)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output int c);
    c = 0;
    do begin
      tick();
      c++;
    end while (gnt == 4'b0 && c < 40);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while (busy && c < 40) begin
      tick();
      c++;
    end
    tick();
  endtask

  task automatic do_reset();
    req   = 4'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    req   = 4'b1111;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    checks++;
    if ({gnt, rsp_valid, busy, dut_en, dut_rw} !== 11'b0) begin
      failures++;
      $display("FAIL reset_ctrl got gnt=%b rsp_valid=%b busy=%b dut_en=%b dut_rw=%b want all 0",
               gnt, rsp_valid, busy, dut_en, dut_rw);
    end
    checks++;
    if ({rsp_data, dut_addr, dut_datain} !== 96'b0) begin
      failures++;
      $display("FAIL reset_data got rsp_data=%h dut_addr=%h dut_datain=%h want 0",
               rsp_data, dut_addr, dut_datain);
    end
    reset = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_gnt got %b want 0001", gnt);
    end
    req = 4'b0;
    wait_idle();
  endtask

  task automatic test_single();
    int n;
    int held_err;
    do_reset();
    dut_dataout       = 32'h1234_5678;
    req_addr[64 +: 32] = 32'h10;
    req_data[64 +: 32] = 32'hA5A5_0F0F;
    req_rw[2]          = 1'b1;
    req                = 4'b0100;
    tick();
    req = 4'b0;
    checks++;
    if (gnt !== 4'b0100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_gnt got gnt=%b busy=%b want 0100 1", gnt, busy);
    end
    checks++;
    if (dut_addr !== 32'h10 || dut_datain !== 32'hA5A5_0F0F || dut_rw !== 1'b1) begin
      failures++;
      $display("FAIL single_bus got addr=%h data=%h rw=%b want 00000010 a5a50f0f 1",
               dut_addr, dut_datain, dut_rw);
    end
    n = dut_en ? 1 : 0;
    held_err = 0;
    tick();
    checks++;
    if (gnt !== 4'b0) begin
      failures++;
      $display("FAIL single_gnt_pulse got %b want 0000", gnt);
    end
    while (dut_en && n < 40) begin
      n++;
      if (dut_addr !== 32'h10 || dut_datain !== 32'hA5A5_0F0F || rsp_valid !== 4'b0) held_err++;
      tick();
    end
    checks++;
    if (n !== 16) begin
      failures++;
      $display("FAIL single_en_len got %0d want 16", n);
    end
    checks++;
    if (held_err !== 0) begin
      failures++;
      $display("FAIL single_hold got %0d bad cycles want 0", held_err);
    end
    checks++;
    if (rsp_valid !== 4'b0100 || rsp_data !== 32'h1234_5678 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_rsp got rsp_valid=%b rsp_data=%h busy=%b want 0100 12345678 1",
               rsp_valid, rsp_data, busy);
    end
    tick();
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0 || dut_addr !== 32'h10) begin
      failures++;
      $display("FAIL single_end got rsp_valid=%b busy=%b addr=%h want 0000 0 00000010",
               rsp_valid, busy, dut_addr);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g [5];
    int c;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_gnt(c);
      checks++;
      if (gnt !== exp_g[i]) begin
        failures++;
        $display("FAIL rr_order%0d got %b want %b", i, gnt, exp_g[i]);
      end
      if (i > 0) begin
        checks++;
        if (c !== 18) begin
          failures++;
          $display("FAIL rr_spacing%0d got %0d cycles want 18", i, c);
        end
      end
    end
    req = 4'b0;
    wait_idle();
  endtask

  task automatic test_wrap();
    int c;
    do_reset();
    req = 4'b0100;
    tick();
    req = 4'b0;
    wait_idle();
    req = 4'b0011;
    wait_gnt(c);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL wrap_first got %b want 0001", gnt);
    end
    req = 4'b0010;
    wait_gnt(c);
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL wrap_second got %b want 0010", gnt);
    end
    req = 4'b0;
    wait_idle();
  endtask

  task automatic test_reset_mid();
    int c;
    int seen;
    do_reset();
    req = 4'b0001;
    tick();
    req = 4'b0;
    wait_idle();
    req = 4'b0100;
    tick();
    req = 4'b0;
    for (int i = 0; i < 10; i++) tick();
    reset = 1'b0;
    tick();
    reset = 1'b1;
    checks++;
    if (busy !== 1'b0 || dut_en !== 1'b0 || rsp_valid !== 4'b0 || gnt !== 4'b0) begin
      failures++;
      $display("FAIL mid_reset_state got busy=%b en=%b rsp_valid=%b gnt=%b want 0 0 0000 0000",
               busy, dut_en, rsp_valid, gnt);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (rsp_valid !== 4'b0 || busy !== 1'b0) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL mid_reset_quiet got %0d active cycles want 0", seen);
    end
    req = 4'b0111;
    wait_gnt(c);
    checks++;
    if (gnt !== 4'b0001 || c !== 1) begin
      failures++;
      $display("FAIL mid_reset_next got gnt=%b after %0d want 0001 after 1", gnt, c);
    end
    req = 4'b0;
    wait_idle();
  endtask

  task automatic test_read_data();
    do_reset();
    dut_dataout        = 32'h1111_1111;
    req_addr[32 +: 32] = 32'hCAFE_0004;
    req_rw[1]          = 1'b0;
    req                = 4'b0010;
    tick();
    req = 4'b0;
    checks++;
    if (gnt !== 4'b0010 || dut_rw !== 1'b0 || dut_addr !== 32'hCAFE_0004) begin
      failures++;
      $display("FAIL read_gnt got gnt=%b rw=%b addr=%h want 0010 0 cafe0004", gnt, dut_rw, dut_addr);
    end
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (dut_en !== 1'b1 || rsp_valid !== 4'b0) begin
      failures++;
      $display("FAIL read_last_beat got en=%b rsp_valid=%b want 1 0000", dut_en, rsp_valid);
    end
    dut_dataout = 32'hDEAD_BEEF;
    tick();
    dut_dataout = 32'h0;
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_data !== 32'hDEAD_BEEF || dut_en !== 1'b0) begin
      failures++;
      $display("FAIL read_capture got rsp_valid=%b rsp_data=%h en=%b want 0010 deadbeef 0",
               rsp_valid, rsp_data, dut_en);
    end
    tick();
    checks++;
    if (rsp_data !== 32'hDEAD_BEEF || rsp_valid !== 4'b0) begin
      failures++;
      $display("FAIL read_hold got rsp_data=%h rsp_valid=%b want deadbeef 0000", rsp_data, rsp_valid);
    end
  endtask

  initial begin
    reset       = 1'b0;
    req         = 4'b0;
    req_rw      = 4'b0;
    dut_dataout = 32'h0;
    for (int i = 0; i < 4; i++) begin
      req_addr[i*32 +: 32] = 32'h100 + 32'(i);
      req_data[i*32 +: 32] = 32'h5000 + 32'(i);
    end
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_reset_mid();
    test_read_data();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
